// File: rtl/mem_addr_gen.sv
// mem_addr_gen: strided up-to-3-D address generator with a valid/ready output handshake.
// Optional macro MEM_ADDR_GEN_CIRCULAR_EN adds circular_en to rerun the sequence without leaving RUN.
module mem_addr_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        flush,
   input  logic        start,
   input  logic [15:0] starting_addr,
   input  logic [3:0]  dimensionality,
   input  logic [15:0] stride_0,
   input  logic [15:0] stride_1,
   input  logic [15:0] stride_2,
   input  logic [15:0] range_0,
   input  logic [15:0] range_1,
   input  logic [15:0] range_2,
   input  logic [31:0] iter_cnt,
`ifdef MEM_ADDR_GEN_CIRCULAR_EN
   input  logic        circular_en,
`endif
   input  logic        addr_ready,
   output logic [15:0] addr_out,
   output logic        addr_valid,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t      r_state, w_state_nx;
   logic [15:0] r_base, r_s0, r_s1, r_s2, r_r0, r_r1, r_r2;
   logic [15:0] r_idx0, r_idx1, r_idx2, w_idx0_nx, w_idx1_nx, w_idx2_nx;
   logic [1:0]  r_dim;
   logic [31:0] r_iter, r_cnt, w_cnt_nx;
   logic        r_valid, r_done, w_valid_nx, w_done_nx, w_load, w_circ;
   logic        w_xfer, w_last, w_wrap0, w_wrap1, w_wrap2;

   assign w_xfer  = r_valid & addr_ready;
   assign w_last  = (r_cnt + 32'd1) == r_iter;
   assign w_wrap0 = r_idx0 == r_r0 - 16'd1;
   assign w_wrap1 = r_idx1 == r_r1 - 16'd1;
   assign w_wrap2 = r_idx2 == r_r2 - 16'd1;

`ifdef MEM_ADDR_GEN_CIRCULAR_EN
   logic r_circ;
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_circ <= 1'b0;
      else if (clk_en && w_load) r_circ <= circular_en;
   assign w_circ = r_circ;
`else
   assign w_circ = 1'b0;
`endif

   always_comb begin
      w_state_nx = r_state;
      w_idx0_nx  = r_idx0;
      w_idx1_nx  = r_idx1;
      w_idx2_nx  = r_idx2;
      w_cnt_nx   = r_cnt;
      w_valid_nx = r_valid;
      w_done_nx  = 1'b0;
      w_load     = 1'b0;
      if (flush) begin
         w_state_nx = S_IDLE;
         w_idx0_nx  = '0;
         w_idx1_nx  = '0;
         w_idx2_nx  = '0;
         w_cnt_nx   = '0;
         w_valid_nx = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               w_load     = 1'b1;
               w_idx0_nx  = '0;
               w_idx1_nx  = '0;
               w_idx2_nx  = '0;
               w_cnt_nx   = '0;
               w_state_nx = (iter_cnt != 32'd0) ? S_RUN : S_DONE;
               w_valid_nx = iter_cnt != 32'd0;
               w_done_nx  = iter_cnt == 32'd0;
            end
            S_RUN: if (w_xfer) begin
               if (w_last) begin
                  w_idx0_nx  = '0;
                  w_idx1_nx  = '0;
                  w_idx2_nx  = '0;
                  w_cnt_nx   = '0;
                  w_done_nx  = 1'b1;
                  w_state_nx = w_circ ? S_RUN : S_DONE;
                  w_valid_nx = w_circ;
               end else begin
                  w_cnt_nx  = r_cnt + 32'd1;
                  w_idx0_nx = w_wrap0 ? '0 : r_idx0 + 16'd1;
                  if (w_wrap0 && r_dim >= 2'd2) w_idx1_nx = w_wrap1 ? '0 : r_idx1 + 16'd1;
                  if (w_wrap0 && w_wrap1 && r_dim == 2'd3) w_idx2_nx = w_wrap2 ? '0 : r_idx2 + 16'd1;
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_state <= S_IDLE;
         r_idx0  <= '0;
         r_idx1  <= '0;
         r_idx2  <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else if (clk_en) begin
         r_state <= w_state_nx;
         r_idx0  <= w_idx0_nx;
         r_idx1  <= w_idx1_nx;
         r_idx2  <= w_idx2_nx;
         r_cnt   <= w_cnt_nx;
         r_valid <= w_valid_nx;
         r_done  <= w_done_nx;
      end

   // Zero ranges and out-of-range dimensionality are normalised once, at latch time.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_base <= '0;
         r_s0   <= '0;
         r_s1   <= '0;
         r_s2   <= '0;
         r_r0   <= '0;
         r_r1   <= '0;
         r_r2   <= '0;
         r_dim  <= '0;
         r_iter <= '0;
      end else if (clk_en && w_load) begin
         r_base <= starting_addr;
         r_s0   <= stride_0;
         r_s1   <= stride_1;
         r_s2   <= stride_2;
         r_r0   <= (range_0 == 16'd0) ? 16'd1 : range_0;
         r_r1   <= (range_1 == 16'd0) ? 16'd1 : range_1;
         r_r2   <= (range_2 == 16'd0) ? 16'd1 : range_2;
         r_dim  <= (dimensionality == 4'd0) ? 2'd1 : (dimensionality > 4'd3) ? 2'd3 : dimensionality[1:0];
         r_iter <= iter_cnt;
      end

   assign addr_out   = r_base + r_idx0 * r_s0 + r_idx1 * r_s1 + r_idx2 * r_s2;
   assign addr_valid = r_valid;
   assign busy       = r_state == S_RUN;
   assign done       = r_done;
endmodule
